// File: rtl/drv_segment_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
// Segment codes are active-low with bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } seg_scan_t;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  // Anode pattern with only digit idx driven, honouring the strobe polarity.
  function automatic logic [MAX_DIGITS-1:0] an_mask(input logic [2:0] idx, input logic an_low);
    logic [MAX_DIGITS-1:0] onehot;
    onehot = 8'b0000_0001 << idx;
    return an_low ? ~onehot : onehot;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] an_off(input logic an_low);
    return an_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/drv_segment_scan_if.sv
// Application-side and pin-side signals of the scan controller, grouped as one bundle.
interface drv_segment_scan_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] i_val;
  logic [DIGITS-1:0]   i_dp;
  logic [DIGITS-1:0]   i_en;
  logic                i_lzs;
  logic                i_load;
  logic                o_ack;
  logic                o_frame;
  logic [6:0]          o_sgmnt;
  logic                o_dp;
  logic [DIGITS-1:0]   o_an;

  modport master (
    output i_val, i_dp, i_en, i_lzs, i_load,
    input  o_ack, o_frame, o_sgmnt, o_dp, o_an
  );

  modport slave (
    input  i_val, i_dp, i_en, i_lzs, i_load,
    output o_ack, o_frame, o_sgmnt, o_dp, o_an
  );
endinterface

// File: rtl/drv_segment_hex.sv
// Combinational hex-to-7-segment decoder, active-low {g,f,e,d,c,b,a}.
// Codes above 0xF leave the digit dark.
module drv_segment_hex
  import seg_pkg::*;
(
  input  logic [4:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      5'h00: seg = 7'h40;
      5'h01: seg = 7'h79;
      5'h02: seg = 7'h24;
      5'h03: seg = 7'h30;
      5'h04: seg = 7'h19;
      5'h05: seg = 7'h12;
      5'h06: seg = 7'h02;
      5'h07: seg = 7'h78;
      5'h08: seg = 7'h00;
      5'h09: seg = 7'h10;
      5'h0A: seg = 7'h08;
      5'h0B: seg = 7'h03;
      5'h0C: seg = 7'h46;
      5'h0D: seg = 7'h21;
      5'h0E: seg = 7'h06;
      5'h0F: seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/drv_segment_scan.sv
// Time-multiplexed common-anode 7-segment scanner with blanking dead time
// and a double-buffered display image swapped only at frame boundaries.
module drv_segment_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int BLANK  = 64,
  parameter int AN_LOW = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  drv_segment_scan_if.slave  bus
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;

  seg_scan_t         state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic              frame_start;

  logic [VW-1:0]     pend_val_reg, act_val_reg;
  logic [DIGITS-1:0] pend_dp_reg, pend_en_reg, act_dp_reg, act_en_reg;
  logic              pend_lzs_reg, act_lzs_reg, pend_flag_reg;

  logic [DIGITS-1:0] an_reg, an_next;
  logic [6:0]        sgmnt_reg, sgmnt_next;
  logic              dp_reg, dp_next;
  logic              ack_reg, frame_reg;

  logic [DIGITS-1:0] hi_zero;
  logic [3:0]        nib_sel;
  logic              dp_sel, en_sel, blank_lz, lit;
  logic [6:0]        seg_dec;

  // ---------------- slot sequencer ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= S_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    case (state_reg)
      S_BLANK: begin
        if (cnt_reg == CW'(BLANK - 1)) state_next = S_SHOW;
      end
      S_SHOW: begin
        if (cnt_reg == CW'(DIV - 1)) begin
          state_next = S_BLANK;
          cnt_next   = '0;
          idx_next   = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
        end
      end
      default: state_next = S_BLANK;
    endcase
  end

  // First cycle of every frame, including the one right after reset.
  assign frame_start = (state_reg == S_BLANK) && (cnt_reg == '0) && (idx_reg == '0);

  // ---------------- pending / active buffers ----------------
  // A load always wins over an apply, so a load landing on the boundary waits a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_val_reg  <= '0;
      pend_dp_reg   <= '0;
      pend_en_reg   <= '0;
      pend_lzs_reg  <= 1'b0;
      pend_flag_reg <= 1'b0;
      act_val_reg   <= '0;
      act_dp_reg    <= '0;
      act_en_reg    <= '0;
      act_lzs_reg   <= 1'b0;
      ack_reg       <= 1'b0;
    end else begin
      ack_reg <= 1'b0;
      if (bus.i_load) begin
        pend_val_reg  <= bus.i_val;
        pend_dp_reg   <= bus.i_dp;
        pend_en_reg   <= bus.i_en;
        pend_lzs_reg  <= bus.i_lzs;
        pend_flag_reg <= 1'b1;
      end else if (frame_start && pend_flag_reg) begin
        act_val_reg   <= pend_val_reg;
        act_dp_reg    <= pend_dp_reg;
        act_en_reg    <= pend_en_reg;
        act_lzs_reg   <= pend_lzs_reg;
        pend_flag_reg <= 1'b0;
        ack_reg       <= 1'b1;
      end
    end
  end

  // hi_zero[k]: every nibble from digit k up to the top digit is zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hi_zero
      assign hi_zero[gi] = (act_val_reg[VW-1:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    nib_sel  = act_val_reg[{idx_reg, 2'b00} +: 4];
    dp_sel   = act_dp_reg[idx_reg];
    en_sel   = act_en_reg[idx_reg];
    blank_lz = act_lzs_reg && (idx_reg != '0) && hi_zero[idx_reg] && !dp_sel;
    lit      = (state_reg == S_SHOW) && en_sel && !blank_lz;
  end

  drv_segment_hex u_hex (
    .nibble ({1'b0, nib_sel}),
    .seg    (seg_dec)
  );

  always_comb begin
    an_next    = DIGITS'(an_off(AN_LOW != 0));
    sgmnt_next = SEG_OFF;
    dp_next    = 1'b1;
    if (lit) begin
      an_next    = DIGITS'(an_mask(3'(idx_reg), AN_LOW != 0));
      sgmnt_next = seg_dec;
      dp_next    = ~dp_sel;
    end
  end

  // ---------------- registered pins ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      an_reg    <= DIGITS'(an_off(AN_LOW != 0));
      sgmnt_reg <= SEG_OFF;
      dp_reg    <= 1'b1;
      frame_reg <= 1'b0;
    end else begin
      an_reg    <= an_next;
      sgmnt_reg <= sgmnt_next;
      dp_reg    <= dp_next;
      frame_reg <= frame_start;
    end
  end

  assign bus.o_an    = an_reg;
  assign bus.o_sgmnt = sgmnt_reg;
  assign bus.o_dp    = dp_reg;
  assign bus.o_ack   = ack_reg;
  assign bus.o_frame = frame_reg;

endmodule
